// File: rtl/mul_hilo_sequencer.sv
// Multicycle issue/writeback stage for the external 32x32 signed multiplier:
// holds operands stable for MUL_CYCLES settle cycles, then writes HI/LO.
module mul_hilo_sequencer #(
   parameter int unsigned MUL_CYCLES = 4
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   input  logic        flush,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_z,
   input  logic [31:0] hi_in,
   input  logic [31:0] lo_in,
   input  logic        hi_wr,
   input  logic        lo_wr,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;
   localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

   logic [0:0] state;
   logic [3:0] count;

   // Multiplier inputs come straight from flops so the product path is a clean multicycle path.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state  <= IDLE;
         count  <= '0;
         mul_a  <= '0;
         mul_b  <= '0;
         hi_out <= '0;
         lo_out <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (hi_wr) hi_out <= hi_in;
               if (lo_wr) lo_out <= lo_in;
               if (start) begin
                  mul_a <= a_in;
                  mul_b <= b_in;
                  count <= CNT_LOAD;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (flush) begin
                  state <= IDLE;
               end else if (count == 4'd0) begin
                  hi_out <= mul_z[63:32];
                  lo_out <= mul_z[31:0];
                  done   <= 1'b1;
                  state  <= IDLE;
               end else begin
                  count <= count - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == WAIT);

endmodule
